// File: rtl/result_byte_serializer.sv
// Captures one DATA_W-bit result on ld and streams it out LSB-first as BYTE_W beats
// over valid/ready; a ld that arrives while a word is held is dropped and flagged on ovr.
module result_byte_serializer #(
  parameter int DATA_W = 100,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              ovr
);
  localparam int NBEATS = (DATA_W + BYTE_W - 1) / BYTE_W;
  localparam int SH_W   = NBEATS * BYTE_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [SH_W-1:0]   shreg;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  assign cnt_nxt = cnt + CNT_W'(1);
  // Beat is the low slice of the shift register; it drains to zero, so m_data is 0 when idle.
  assign m_data  = shreg[BYTE_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      ovr <= 1'b0;
      case (state)
        IDLE: begin
          if (ld) begin
            shreg   <= SH_W'(din);
            cnt     <= '0;
            state   <= SEND;
            busy    <= 1'b1;
            m_valid <= 1'b1;
            m_last  <= (NBEATS == 1);
          end
        end
        SEND: begin
          // Held word has priority; even a ld alongside the final accept is dropped.
          if (ld) ovr <= 1'b1;
          if (m_ready) begin
            shreg <= shreg >> BYTE_W;
            cnt   <= cnt_nxt;
            if (m_last) begin
              state   <= IDLE;
              busy    <= 1'b0;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end else begin
              m_last <= (cnt_nxt == CNT_W'(NBEATS - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_byte_serializer.sv
// Directed bench for result_byte_serializer: scoreboard of expected beats checked by
// a negedge monitor, plus cycle-level checks of reset, overrun and stall behaviour.
module tb_result_byte_serializer;
  localparam int DATA_W = 100;
  localparam int BYTE_W = 8;
  localparam int NB     = 13;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ld = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              busy;
  logic [BYTE_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              m_last;
  logic              ovr;

  int    n_cmp = 0;
  int    n_err = 0;
  int    n_xfer = 0;
  beat_t exp_q[$];

  result_byte_serializer #(.DATA_W(DATA_W), .BYTE_W(BYTE_W)) dut (
    .clk(clk), .rst(rst), .ld(ld), .din(din), .busy(busy), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    logic [NB*8-1:0] x;
    x = {{(NB*8-DATA_W){1'b0}}, w};
    for (int k = 0; k < NB; k++) push_beat(x[8*k +: 8], k == NB - 1);
  endtask

  task automatic drain(input bit rnd, input int max_cyc);
    int c;
    c = 0;
    while ((busy || exp_q.size() != 0) && c < max_cyc) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    m_ready = 1'b1;
    chk("drain_timeout", 128'(c < max_cyc), 128'(1));
  endtask

  // Transfer monitor: inputs change just after posedge, so negedge sees the handshake
  // exactly as the next posedge will.
  logic [7:0] hold_d;
  logic       hold_l;
  bit         stalled = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 128'(m_valid), 128'(1));
        chk("stall_data", 128'(m_data), 128'(hold_d));
        chk("stall_last", 128'(m_last), 128'(hold_l));
      end
      if (m_valid && m_ready) begin
        stalled = 1'b0;
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 128'(m_data), 128'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 128'(m_data), 128'(e.d));
          chk("beat_last", 128'(m_last), 128'(e.l));
        end
      end else if (m_valid) begin
        stalled = 1'b1;
        hold_d  = m_data;
        hold_l  = m_last;
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] w;
    int x0;

    // 1: reset values, ld ignored during reset, async abort mid-word
    ld  = 1'b1;
    din = {DATA_W{1'b1}};
    step();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(m_valid), 128'(0));
    chk("rst_last", 128'(m_last), 128'(0));
    chk("rst_data", 128'(m_data), 128'(0));
    chk("rst_ovr", 128'(ovr), 128'(0));
    ld = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_ld_ignored", 128'(m_valid), 128'(0));
    w = {$urandom, $urandom, $urandom, $urandom};
    din = w;
    ld = 1'b1;
    push_word(w);
    step();
    ld = 1'b0;
    step();
    step();
    chk("pre_abort_valid", 128'(m_valid), 128'(1));
    #2 rst = 1'b0;
    #1;
    chk("abort_outputs", 128'({busy, m_valid, m_last, ovr, m_data}), 128'(0));
    exp_q.delete();
    step();
    rst = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_abort_idle", 128'({busy, m_valid}), 128'(0));
    end

    // 2: counting pattern, ready high, exact timing
    w = '0;
    for (int k = 0; k < 12; k++) w |= DATA_W'(k) << (8 * k);
    w |= DATA_W'(5) << 96;
    for (int k = 0; k < 12; k++) push_beat(8'(k), 1'b0);
    push_beat(8'h05, 1'b1);
    din = w;
    ld = 1'b1;
    chk("lat_valid_before", 128'(m_valid), 128'(0));
    step();
    ld = 1'b0;
    chk("lat_valid_after", 128'(m_valid), 128'(1));
    chk("lat_busy", 128'(busy), 128'(1));
    chk("first_beat", 128'({m_last, m_data}), 128'(9'h000));
    for (int i = 0; i < 12; i++) step();
    chk("beat13_last", 128'({m_last, m_data}), 128'(9'h105));
    step();
    chk("word_end_idle", 128'({busy, m_valid}), 128'(0));
    chk("word2_consumed", 128'(exp_q.size()), 128'(0));

    // 3: all-ones with random backpressure
    x0 = n_xfer;
    din = {DATA_W{1'b1}};
    for (int k = 0; k < 12; k++) push_beat(8'hFF, 1'b0);
    push_beat(8'h0F, 1'b1);
    ld = 1'b1;
    step();
    ld = 1'b0;
    drain(1'b1, 400);
    chk("ones_xfer_count", 128'(n_xfer - x0), 128'(NB));

    // 4: ld on the third SEND cycle is dropped
    w = {$urandom, $urandom, $urandom, $urandom};
    push_word(w);
    din = w;
    ld = 1'b1;
    step();
    ld = 1'b0;
    step();
    step();
    din = ~w;
    ld = 1'b1;
    step();
    ld = 1'b0;
    chk("ovr_pulse", 128'(ovr), 128'(1));
    chk("ovr_busy", 128'(busy), 128'(1));
    step();
    chk("ovr_one_cycle", 128'(ovr), 128'(0));
    drain(1'b0, 100);

    // 5: ld coincident with the last-beat accept
    w = {$urandom, $urandom, $urandom, $urandom};
    push_word(w);
    din = w;
    ld = 1'b1;
    step();
    ld = 1'b0;
    for (int i = 0; i < 40 && !m_last; i++) step();
    chk("reach_last", 128'(m_last), 128'(1));
    din = ~w;
    ld = 1'b1;
    step();
    ld = 1'b0;
    chk("coinc_ovr", 128'(ovr), 128'(1));
    chk("coinc_idle", 128'({busy, m_valid}), 128'(0));
    w = {$urandom, $urandom, $urandom, $urandom};
    push_word(w);
    din = w;
    ld = 1'b1;
    step();
    ld = 1'b0;
    chk("recapture_valid", 128'(m_valid), 128'(1));
    chk("recapture_ovr", 128'(ovr), 128'(0));
    drain(1'b0, 100);

    // 6: long stall right after ld
    m_ready = 1'b0;
    w = {$urandom, $urandom, $urandom, $urandom};
    push_word(w);
    din = w;
    ld = 1'b1;
    step();
    ld = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("hold_state", 128'({busy, m_valid, m_data}), 128'({2'b11, w[7:0]}));
    end
    m_ready = 1'b1;
    drain(1'b0, 100);
    step();
    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
